tnn_popcount_accumulator: RTL and testbench

Sequential stage directly downstream of the 14-input approximate popcount unit in the ternary neural network datapath. Accepts one 4-bit popcount per beat (one 14-bit input slice of a neuron's fan-in), accumulates `CHUNKS` beats into a neuron sum, and compares the sum against two thresholds to emit a ternary activation. Valid/ready handshake on both sides, one neuron in flight.

---
 rtl/tnn_popcount_accumulator_if.sv | 24 ++
 rtl/tnn_popcount_accumulator.sv | 93 +++++++++
 tb/tb_tnn_popcount_accumulator.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tnn_popcount_accumulator_if.sv
// Handshake bundle between the popcount unit, the accumulator and the activation consumer.
interface tnn_popcount_accumulator_if #(
    parameter int ACC_W = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_pop;
    logic [ACC_W-1:0] thr_lo;
    logic [ACC_W-1:0] thr_hi;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_trit;
    logic [ACC_W-1:0] out_sum;

    modport master (
        output in_valid, in_pop, thr_lo, thr_hi, out_ready,
        input  in_ready, out_valid, out_trit, out_sum
    );

    modport slave (
        input  in_valid, in_pop, thr_lo, thr_hi, out_ready,
        output in_ready, out_valid, out_trit, out_sum
    );
endinterface

// File: rtl/tnn_popcount_accumulator.sv
// Purpose: accumulate CHUNKS popcount beats into a saturated neuron sum, threshold to a trit.
// Latency: out_valid rises one cycle after the final beat is accepted.
// Backpressure: in_ready is low while a result is held; it returns the cycle after the output handshake.
module tnn_popcount_accumulator #(
    parameter int CHUNKS = 8,
    parameter int ACC_W  = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    tnn_popcount_accumulator_if.slave  bus
);
    localparam int               CNT_W   = $clog2(CHUNKS);
    localparam int               SUM_W   = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(CHUNKS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] thr_lo_q, thr_hi_q;
    logic [ACC_W-1:0] sum_q;
    logic [1:0]       trit_q;

    logic             beat;
    logic             last_beat;
    logic [SUM_W-1:0] sum_wide;
    logic [ACC_W-1:0] sum_sat;
    logic [1:0]       trit_d;

    always_comb begin
        beat      = bus.in_valid && (state_q == ACCUM);
        last_beat = beat && (cnt_q == LAST);

        // One spare bit catches the carry so saturation never wraps.
        sum_wide = {1'b0, acc_q} + SUM_W'(bus.in_pop);
        sum_sat  = sum_wide[ACC_W] ? ACC_MAX : sum_wide[ACC_W-1:0];

        // +1 wins when thresholds are inverted.
        trit_d = 2'b00;
        if (sum_sat > thr_hi_q) begin
            trit_d = 2'b01;
        end else if (sum_sat < thr_lo_q) begin
            trit_d = 2'b11;
        end

        state_d = state_q;
        case (state_q)
            ACCUM:   if (last_beat) state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACCUM;
            acc_q    <= '0;
            cnt_q    <= '0;
            thr_lo_q <= '0;
            thr_hi_q <= '0;
            sum_q    <= '0;
            trit_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            if (beat) begin
                if (cnt_q == '0) begin
                    thr_lo_q <= bus.thr_lo;
                    thr_hi_q <= bus.thr_hi;
                end
                if (last_beat) begin
                    acc_q  <= '0;
                    cnt_q  <= '0;
                    sum_q  <= sum_sat;
                    trit_q <= trit_d;
                end else begin
                    acc_q <= sum_sat;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // The state flop is a single bit, so both handshake outputs come straight off a register.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sum   = sum_q;
    assign bus.out_trit  = trit_q;
endmodule

// File: tb/tb_tnn_popcount_accumulator.sv
// Directed vectors for the popcount accumulator: thresholds, capture, backpressure, saturation, reset.
module tb_tnn_popcount_accumulator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tnn_popcount_accumulator_if #(.ACC_W(7)) a_if ();
    tnn_popcount_accumulator_if #(.ACC_W(6)) b_if ();

    tnn_popcount_accumulator #(.CHUNKS(8), .ACC_W(7)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    tnn_popcount_accumulator #(.CHUNKS(8), .ACC_W(6)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    typedef struct {
        string           name;
        logic [7:0][3:0] pops;
        logic [6:0]      lo;
        logic [6:0]      hi;
        logic [6:0]      sum;
        logic [1:0]      trit;
    } vec_t;

    vec_t vecs [9];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat on DUT A, optionally preceded by idle cycles carrying junk pops.
    task automatic a_beat(input logic [3:0] pop, input logic [6:0] lo, input logic [6:0] hi,
                          input int gap_max);
        int gaps;
        int n;
        gaps = int'($urandom_range(gap_max, 0));
        repeat (gaps) begin
            a_if.in_valid = 1'b0;
            a_if.in_pop   = 4'($urandom_range(15, 0));
            tick();
        end
        a_if.in_valid = 1'b1;
        a_if.in_pop   = pop;
        a_if.thr_lo   = lo;
        a_if.thr_hi   = hi;
        n = 0;
        while (a_if.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("a_in_ready_wait", 32'(a_if.in_ready), 1);
        tick();
        a_if.in_valid = 1'b0;
    endtask

    // Thresholds are scrambled after the first beat; the result must use the captured ones.
    task automatic a_neuron(input int v, input int gap_max, input bit handshake);
        for (int b = 0; b < 8; b++) begin
            if (b == 7) check({vecs[v].name, "_early_valid"}, 32'(a_if.out_valid), 0);
            a_beat(vecs[v].pops[b],
                   (b == 0) ? vecs[v].lo : (vecs[v].lo ^ 7'h2A),
                   (b == 0) ? vecs[v].hi : (vecs[v].hi ^ 7'h15),
                   gap_max);
        end
        check({vecs[v].name, "_out_valid"}, 32'(a_if.out_valid), 1);
        check({vecs[v].name, "_in_ready_hold"}, 32'(a_if.in_ready), 0);
        check({vecs[v].name, "_sum"}, 32'(a_if.out_sum), 32'(vecs[v].sum));
        check({vecs[v].name, "_trit"}, 32'(a_if.out_trit), 32'(vecs[v].trit));
        if (handshake) begin
            a_if.out_ready = 1'b1;
            tick();
            check({vecs[v].name, "_valid_drop"}, 32'(a_if.out_valid), 0);
            check({vecs[v].name, "_in_ready_back"}, 32'(a_if.in_ready), 1);
        end
    endtask

    task automatic b_neuron(input string name, input logic [7:0][3:0] pops, input logic [5:0] lo,
                            input logic [5:0] hi, input logic [5:0] exp_sum, input logic [1:0] exp_trit);
        for (int b = 0; b < 8; b++) begin
            if (b == 7) check({name, "_early_valid"}, 32'(b_if.out_valid), 0);
            check({name, "_in_ready"}, 32'(b_if.in_ready), 1);
            b_if.in_valid = 1'b1;
            b_if.in_pop   = pops[b];
            b_if.thr_lo   = (b == 0) ? lo : ~lo;
            b_if.thr_hi   = (b == 0) ? hi : ~hi;
            tick();
            b_if.in_valid = 1'b0;
        end
        check({name, "_out_valid"}, 32'(b_if.out_valid), 1);
        check({name, "_sum"}, 32'(b_if.out_sum), 32'(exp_sum));
        check({name, "_trit"}, 32'(b_if.out_trit), 32'(exp_trit));
        tick();
        check({name, "_valid_drop"}, 32'(b_if.out_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"basic_plus",  {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1}, 7'd20, 7'd30, 7'd36,  2'b01};
        vecs[1] = '{"eq_hi",       {4'd3, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4}, 7'd20, 7'd30, 7'd30,  2'b00};
        vecs[2] = '{"below_lo",    {4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3}, 7'd20, 7'd30, 7'd19,  2'b11};
        vecs[3] = '{"eq_lo",       {4'd1, 4'd1, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3}, 7'd20, 7'd30, 7'd20,  2'b00};
        vecs[4] = '{"inverted",    {4'd1, 4'd1, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3}, 7'd40, 7'd10, 7'd20,  2'b01};
        vecs[5] = '{"all_zero",    {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 7'd0,  7'd0,  7'd0,   2'b00};
        vecs[6] = '{"max_plus",    {4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15}, 7'd0, 7'd119, 7'd120, 2'b01};
        vecs[7] = '{"max_minus",   {4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15}, 7'd121, 7'd126, 7'd120, 2'b11};
        vecs[8] = '{"after_reset", {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 7'd1,  7'd5,  7'd0,   2'b11};

        rst            = 1'b1;
        a_if.in_valid  = 1'b0;
        a_if.in_pop    = 4'd0;
        a_if.thr_lo    = 7'd0;
        a_if.thr_hi    = 7'd0;
        a_if.out_ready = 1'b1;
        b_if.in_valid  = 1'b0;
        b_if.in_pop    = 4'd0;
        b_if.thr_lo    = 6'd0;
        b_if.thr_hi    = 6'd0;
        b_if.out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready",  32'(a_if.in_ready),  1);
        check("rst_out_valid", 32'(a_if.out_valid), 0);
        check("rst_out_trit",  32'(a_if.out_trit),  0);
        check("rst_out_sum",   32'(a_if.out_sum),   0);
        check("rst_b_valid",   32'(b_if.out_valid), 0);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) a_neuron(v, 0, 1'b1);

        // Gapped input must give the gapless results.
        a_neuron(0, 3, 1'b1);
        a_neuron(2, 3, 1'b1);

        // Backpressure: result frozen, input stalled, next neuron starts clean.
        a_if.out_ready = 1'b0;
        a_neuron(0, 0, 1'b0);
        a_if.in_valid = 1'b1;
        a_if.in_pop   = 4'd15;
        for (int c = 0; c < 5; c++) begin
            check("bp_in_ready",  32'(a_if.in_ready),  0);
            check("bp_out_valid", 32'(a_if.out_valid), 1);
            check("bp_sum",       32'(a_if.out_sum),   36);
            check("bp_trit",      32'(a_if.out_trit),  1);
            tick();
        end
        a_if.out_ready = 1'b1;
        tick();
        a_if.in_valid = 1'b0;
        check("bp_release_valid",    32'(a_if.out_valid), 0);
        check("bp_release_in_ready", 32'(a_if.in_ready),  1);
        a_neuron(0, 0, 1'b1);

        // Reset mid-neuron discards the partial sum and beat count.
        for (int b = 0; b < 5; b++) a_beat(4'd15, 7'd10, 7'd20, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready",  32'(a_if.in_ready),  1);
        check("mid_rst_out_valid", 32'(a_if.out_valid), 0);
        a_neuron(8, 0, 1'b1);

        // Reset while holding a result drops it.
        a_if.out_ready = 1'b0;
        a_neuron(0, 0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_if.out_ready = 1'b1;
        check("hold_rst_out_valid", 32'(a_if.out_valid), 0);
        check("hold_rst_in_ready",  32'(a_if.in_ready),  1);
        check("hold_rst_out_sum",   32'(a_if.out_sum),   0);
        a_neuron(1, 0, 1'b1);

        // Six-bit accumulator: 120 clamps to 63, 60 fits.
        b_neuron("sat_63", {4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15}, 6'd0, 6'd62, 6'd63, 2'b01);
        b_neuron("nosat_60", {4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15, 4'd15, 4'd15}, 6'd0, 6'd62, 6'd60, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
